// File: rtl/v3_2_sweep_pkg.sv
// v3_2_sweep_pkg: shared sweep-controller types and sizes
package v3_2_sweep_pkg;
  localparam int VEC_W = 4;
  localparam int N_VEC = 16;
  localparam int ERR_W = 5;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/v3_2_settle_timer.sv
// v3_2_settle_timer: load/count-down timer; expires after SETTLE_CYCLES enabled cycles
// Ports: clk, rst; i_load reloads the count; i_en decrements; o_expire is high at zero.
module v3_2_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  // Loaded one short so that o_expire is seen in the last settle cycle.
  localparam logic [3:0] LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  logic [3:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= LOAD;
    else if (i_en && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end
  assign o_expire = r_cnt == 4'd0;
endmodule

// File: rtl/v3_2_sweep_ctrl.sv
// v3_2_sweep_ctrl: sweeps all 16 {A,B,C,D} vectors into V3_2 and checks E/F against truth tables
// Ports: clk, rst (sync, high); start/abort control; vec_out drives V3_2; e_in/f_in sampled back;
// busy/done/pass/err_cnt/first_err_valid/first_err_idx report results.
// V3_2_SWEEP_CAPTURE_EN adds rd_idx/rd_data to read the captured {E,F} per vector.
module v3_2_sweep_ctrl
  import v3_2_sweep_pkg::*;
#(
  parameter int              SETTLE_CYCLES = 2,
  parameter logic [N_VEC-1:0] EXP_E        = 16'h0000,
  parameter logic [N_VEC-1:0] EXP_F        = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             e_in,
  input  logic             f_in,
`ifdef V3_2_SWEEP_CAPTURE_EN
  input  logic [VEC_W-1:0] rd_idx,
  output logic [1:0]       rd_data,
`endif
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_idx
);
  localparam state_t FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  state_t r_state, w_next;
  logic w_go, w_mis, w_last, w_expire, w_load, w_abort;
  assign w_go    = r_state == IDLE && start && !abort;
  assign w_abort = busy && abort;
  assign w_mis   = (e_in != EXP_E[vec_out]) | (f_in != EXP_F[vec_out]);
  assign w_last  = vec_out == VEC_W'(N_VEC - 1);
  assign w_load  = w_go | (r_state == SAMPLE && !w_last && !abort);
  assign busy    = r_state == SETTLE || r_state == SAMPLE;
  assign done    = r_state == DONE;
  v3_2_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_en     (r_state == SETTLE),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   w_next = w_go ? FIRST : IDLE;
      SETTLE: w_next = abort ? IDLE : w_expire ? SAMPLE : SETTLE;
      SAMPLE: w_next = abort ? IDLE : w_last ? DONE : FIRST;
      DONE:   w_next = IDLE;
    endcase
  end
  // An abort in the SAMPLE cycle discards that vector's result.
  always_ff @(posedge clk) begin
    if (rst || w_go) begin
      vec_out         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      pass            <= 1'b0;
    end else if (w_abort) begin
      vec_out <= '0;
      pass    <= 1'b0;
    end else if (r_state == SAMPLE) begin
      err_cnt <= err_cnt + ERR_W'(w_mis);
      if (w_mis && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= vec_out;
      end
      vec_out <= w_last ? '0 : vec_out + VEC_W'(1);
      if (w_last) pass <= err_cnt == '0 && !w_mis;
    end
  end
`ifdef V3_2_SWEEP_CAPTURE_EN
  logic [1:0] r_cap [N_VEC];
  always_ff @(posedge clk) begin
    if (rst || w_go) r_cap <= '{default: '0};
    else if (r_state == SAMPLE && !abort) r_cap[vec_out] <= {e_in, f_in};
  end
  assign rd_data = r_cap[rd_idx];
`endif
endmodule

// File: tb/tb_v3_2_sweep_ctrl.sv
// tb_v3_2_sweep_ctrl: scoreboard bench for two sweep controllers (settle 2 and settle 0)
module tb_v3_2_sweep_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic [15:0] flip_e [2];
  logic [15:0] flip_f [2];
  logic [3:0] vec [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [4:0] err [2];
  logic       fev [2];
  logic [3:0] fei [2];
  int         t0 [2];
  int         stop [2];
`ifdef V3_2_SWEEP_CAPTURE_EN
  logic [3:0] rd_idx [2];
  logic [1:0] rd_data [2];
`endif
  typedef struct {int g; int cyc; int err; int idx; int fev; int pass;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_d
    localparam int SC = (g == 0) ? 2 : 0;
    localparam int P = SC + 1;
    logic e, f;
    // Reference V3_2: E = A, F = C & D, with per-vector fault injection.
    assign e = vec[g][3] ^ flip_e[g][vec[g]];
    assign f = (vec[g][1] & vec[g][0]) ^ flip_f[g][vec[g]];
    v3_2_sweep_ctrl #(.SETTLE_CYCLES(SC), .EXP_E(16'hFF00), .EXP_F(16'h8888)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start[g]),
      .abort           (abort[g]),
      .e_in            (e),
      .f_in            (f),
`ifdef V3_2_SWEEP_CAPTURE_EN
      .rd_idx          (rd_idx[g]),
      .rd_data         (rd_data[g]),
`endif
      .vec_out         (vec[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .pass            (pass[g]),
      .err_cnt         (err[g]),
      .first_err_valid (fev[g]),
      .first_err_idx   (fei[g])
    );
    always @(negedge clk) begin
      int k;
      exp_t x;
      if (!rst) begin
        k = cyc - t0[g];
        if (cyc > t0[g] && cyc <= stop[g]) begin
          if (k <= 16 * P) begin
            chk($sformatf("busy%0d", g), int'(busy[g]), 1);
            chk($sformatf("vec%0d", g), int'(vec[g]), (k - 1) / P);
          end else begin
            chk($sformatf("end_busy%0d", g), int'(busy[g]), 0);
            chk($sformatf("end_vec%0d", g), int'(vec[g]), 0);
          end
        end
        if (done[g]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done%0d: got done=1 expected none (cycle %0d)", g, cyc);
          end else begin
            x = sb.pop_front();
            chk("done_inst", g, x.g);
            chk("done_cycle", cyc, x.cyc);
            chk("err_cnt", int'(err[g]), x.err);
            chk("first_err_valid", int'(fev[g]), x.fev);
            chk("first_err_idx", int'(fei[g]), x.idx);
            chk("pass", int'(pass[g]), x.pass);
          end
        end
      end
    end
  end
  function automatic int per(int g);
    return (g == 0) ? 3 : 1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(int g, bit push);
    int n = 0;
    int first = 0;
    for (int i = 0; i < 16; i++)
      if (flip_e[g][i] | flip_f[g][i]) begin
        if (n == 0) first = i;
        n++;
      end
    start[g] = 1'b1;
    t0[g] = cyc;
    stop[g] = cyc + 16 * per(g) + 1;
    if (push) sb.push_back('{g, cyc + 1 + 16 * per(g), n, first, int'(n != 0), int'(n == 0)});
    tick();
    start[g] = 1'b0;
  endtask
  task automatic run(int g, bit stray);
    launch(g, 1'b1);
    while (cyc < t0[g] + 1 + 16 * per(g)) begin
      start[g] = stray && cyc == t0[g] + 4;
      tick();
    end
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    chk("b2b_ignored", int'(busy[g]), 0);
`ifdef V3_2_SWEEP_CAPTURE_EN
    for (int j = 0; j < 6; j++) begin
      logic [3:0] iv;
      iv = (j == 0) ? 4'd11 : (j == 1) ? 4'd4 : 4'($urandom_range(15));
      rd_idx[g] = iv;
      #1;
      chk("rd_data", int'(rd_data[g]), int'({iv[3] ^ flip_e[g][iv], (iv[1] & iv[0]) ^ flip_f[g][iv]}));
    end
`endif
    repeat (2) tick();
  endtask
  task automatic wait_vec(int g, int v);
    int n = 0;
    while (int'(vec[g]) != v && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("wait_vec_timeout", n, 0);
  endtask
  task automatic abort_at(int g, int v);
    int n = 0;
    int first = 0;
    for (int i = 0; i < v; i++)
      if (flip_e[g][i] | flip_f[g][i]) begin
        if (n == 0) first = i;
        n++;
      end
    launch(g, 1'b0);
    wait_vec(g, v);
    abort[g] = 1'b1;
    stop[g] = cyc;
    tick();
    abort[g] = 1'b0;
    chk("abort_busy", int'(busy[g]), 0);
    chk("abort_vec", int'(vec[g]), 0);
    chk("abort_pass", int'(pass[g]), 0);
    chk("abort_err", int'(err[g]), n);
    chk("abort_fev", int'(fev[g]), int'(n != 0));
    chk("abort_fei", int'(fei[g]), first);
    repeat (20) tick();
    chk("abort_stays_idle", int'(busy[g]), 0);
  endtask
  task automatic rand_masks(int g);
    flip_e[g] = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
    flip_f[g] = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
  endtask
  task automatic check_reset(int g);
    chk("rst_vec", int'(vec[g]), 0);
    chk("rst_busy", int'(busy[g]), 0);
    chk("rst_done", int'(done[g]), 0);
    chk("rst_pass", int'(pass[g]), 0);
    chk("rst_err", int'(err[g]), 0);
    chk("rst_fev", int'(fev[g]), 0);
    chk("rst_fei", int'(fei[g]), 0);
  endtask
  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      abort[g] = 1'b0;
      flip_e[g] = '0;
      flip_f[g] = '0;
      t0[g] = 0;
      stop[g] = 0;
`ifdef V3_2_SWEEP_CAPTURE_EN
      rd_idx[g] = '0;
`endif
    end
    repeat (3) tick();
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    tick();
    run(0, 1'b0);
    run(1, 1'b0);
    flip_f[0] = 16'h8888;
    run(0, 1'b1);
    flip_e[0] = 16'h0120;
    flip_f[0] = 16'h0000;
    run(0, 1'b0);
    flip_e[0] = '0;
    abort_at(0, 5);
    run(0, 1'b0);
    flip_e[1] = 16'h0014;
    abort_at(1, 5);
    flip_e[1] = '0;
    run(1, 1'b1);
    flip_e[0] = 16'h0042;
    flip_f[0] = 16'h0100;
    launch(0, 1'b0);
    wait_vec(0, 9);
    rst = 1'b1;
    stop[0] = cyc;
    tick();
    rst = 1'b0;
    check_reset(0);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("abort_wins_busy", int'(busy[0]), 0);
    repeat (3) tick();
    for (int r = 0; r < 14; r++) begin
      int g;
      g = $urandom_range(1);
      rand_masks(g);
      if ($urandom_range(3) == 0) abort_at(g, $urandom_range(15));
      else run(g, 1'($urandom_range(1)));
    end
    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/v3_2_sweep_ctrl.md
# v3_2_sweep_ctrl

Sequencer that exhaustively exercises the 4-input/2-output combinational block V3_2 in hardware. On a start pulse it drives all 16 input vectors {A,B,C,D} in ascending order, waits a programmable settle time per vector, samples outputs E and F, and compares them against parameterised expected truth tables. It sits between a board-level start button/host and the V3_2 instance, reporting pass/fail, mismatch count and first failing vector.

## Interface
- SETTLE_CYCLES, 2: cycles vec_out is held before the sampling edge; legal range 0..15.
- EXP_E, 16'h0000: expected E truth table; bit i = expected E for vec_out == i.
- EXP_F, 16'h0000: expected F truth table; same indexing.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel a running sweep.
- vec_out  out  4  {A,B,C,D} drive to V3_2; A = bit 3 (MSB).
- e_in  in  1  E from V3_2.
- f_in  in  1  F from V3_2.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at normal sweep completion.
- pass  out  1  last completed sweep had zero mismatches.
- err_cnt  out  5  mismatching vectors in current/last sweep, 0..16.
- first_err_valid  out  1  at least one mismatch recorded.
- first_err_idx  out  4  index of first mismatching vector.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_idx=0, state IDLE.
- IDLE & start & !abort: clear err_cnt, first_err_*, pass; vec_out=0; busy=1; go SETTLE (or SAMPLE if SETTLE_CYCLES=0).
- SETTLE: count SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: mismatch = (e_in != EXP_E[vec_out]) | (f_in != EXP_F[vec_out]); on mismatch err_cnt+1; if first_err_valid=0, set it and latch first_err_idx=vec_out. If vec_out==15 go DONE, else vec_out+1 and back to SETTLE/SAMPLE.
- DONE: done=1, busy=0, pass=(final err_cnt==0), vec_out=0, go IDLE.
- start while busy: ignored. abort while busy: next cycle IDLE, busy=0, vec_out=0, no done pulse, pass=0, err_cnt and first_err_* hold partial values. abort and start same cycle in IDLE: abort wins, stay IDLE.
- rst mid-sweep: all outputs to reset values next edge, no done.
- err_cnt saturation unnecessary: 5 bits hold 16.

## Timing
- Per-vector period P = SETTLE_CYCLES+1 cycles; vec_out stable for full period; e_in/f_in sampled on the last edge of the period.
- start high at cycle t: vec_out=0 and busy=1 from t+1; vector i driven cycles t+1+i*P .. t+i*P+P.
- done pulses in cycle t+1+16*P; busy low in that cycle; pass/err_cnt final from that cycle, held until next accepted start.
- Back-to-back: start during the done cycle is ignored; earliest accepted start is cycle t+2+16*P.

## Configuration
- V3_2_SWEEP_CAPTURE_EN defined: adds ports rd_idx (in, 4) and rd_data (out, 2); 16x2 register file stores {E,F} sampled per vector; rd_data = capture[rd_idx] combinationally; cleared to 0 on rst and on accepted start.
- Undefined: ports and storage absent; all other behaviour identical.

## Structure
- Package v3_2_sweep_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), VEC_W=4, N_VEC=16, ERR_W=5.
- One sub-module v3_2_settle_timer: load/count-down with expire flag, parameter SETTLE_CYCLES.

## Test plan
- Model DUT E=A, F=C&D; EXP_E=16'hFF00, EXP_F=16'h8888, SETTLE_CYCLES=2; start at t -> vec_out 0..15 each held 3 cycles, done at t+49, pass=1, err_cnt=0, first_err_valid=0.
- Same, model F forced 0 -> err_cnt=4, pass=0, first_err_valid=1, first_err_idx=3.
- SETTLE_CYCLES=0, correct model -> vec_out changes every cycle, done at t+17, pass=1.
- abort asserted while vec_out=5 -> next cycle busy=0, vec_out=0, no done pulse, pass=0; new start later completes normally.
- rst asserted at vec_out=9 -> all outputs reset next edge; start during busy ignored (sweep length unchanged, done at t+49).
- V3_2_SWEEP_CAPTURE_EN, correct model: after done, rd_idx=11 -> rd_data=2'b11; rd_idx=4 -> 2'b00.
